sub_bytes: RTL and testbench

// - AES SubBytes stage: replaces each of the 16 bytes of a 128-bit AES state with its FIPS-197 forward S-box value.
// - Sits in the encryption round datapath between AddRoundKey and ShiftRows.
// - Registered, fully pipelined: one state accepted per cycle, result one cycle later.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_sbox.sv | 11 +
 rtl/sub_bytes.sv | 33 +++
 tb/tb_sub_bytes.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES byte/state types and the forward S-box table
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [127:0] aes_state_t;

  // FIPS-197 forward S-box, indexed by input byte, row = high nibble
  localparam aes_byte_t AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational single-byte forward S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = AES_SBOX[in_byte];

endmodule

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - registered AES SubBytes over a 128-bit state, 1-cycle latency
module sub_bytes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         out_valid,
  output logic [127:0] out_data
);

  aes_state_t sub_data;

  for (genvar k = 0; k < 16; k++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte  (in_data[8*k +: 8]),
      .out_byte (sub_data[8*k +: 8])
    );
  end

  // out_data only loads on in_valid so idle-cycle garbage never reaches it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_data <= sub_data;
    end
  end

endmodule

// File: tb/tb_sub_bytes.sv
// tb/tb_sub_bytes.sv - directed and exhaustive-lane bench for sub_bytes
module tb_sub_bytes;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_valid;
  logic [127:0] out_data;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] ref_sbox [256];

  sub_bytes dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Reference S-box built from the GF(2^8) inverse and affine transform
  function automatic logic [7:0] calc_sbox(input logic [7:0] v);
    logic [7:0] inv = 8'h00;
    if (v != 8'h00) begin
      for (int j = 1; j < 256; j++) begin
        if (gmul(v, 8'(j)) == 8'h01) inv = 8'(j);
      end
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int v = 0; v < 256; v++) ref_sbox[v] = calc_sbox(8'(v));

    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {128{1'b1}};
    step();
    step();
    check1  ("reset_valid", out_valid, 1'b0);
    check128("reset_data",  out_data,  128'h0);

    rst      = 1'b0;
    in_data  = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
    step();
    check1  ("vec1_valid", out_valid, 1'b1);
    check128("vec1_data",  out_data,  128'hd4e0b81e27bfb44111985d52aef1e530);

    in_data  = 128'ha4686b029c9f5b6a7f35ea50f22b4349;
    step();
    check1  ("vec2_valid", out_valid, 1'b1);
    check128("vec2_data",  out_data,  128'h49457f77dedb3902d296875389f11a3b);

    in_valid = 1'b0;
    in_data  = 128'h0123456789abcdeffedcba9876543210;
    step();
    check1  ("bubble1_valid", out_valid, 1'b0);
    check128("bubble1_hold",  out_data,  128'h49457f77dedb3902d296875389f11a3b);
    in_data  = 128'h0;
    step();
    check1  ("bubble2_valid", out_valid, 1'b0);
    check128("bubble2_hold",  out_data,  128'h49457f77dedb3902d296875389f11a3b);

    in_valid = 1'b1;
    in_data  = 128'h0;
    step();
    check1  ("zero_valid", out_valid, 1'b1);
    check128("zero_data",  out_data,  {16{8'h63}});

    in_data  = {128{1'b1}};
    step();
    check128("ones_data", out_data, {16{8'h16}});

    in_data  = 128'h000102030405060708090a0b0c0d0e0f;
    step();
    check128("ramp_data", out_data, 128'h637c777bf26b6fc53001672bfed7ab76);

    in_data  = {16{8'h53}};
    step();
    check128("anchor53_data", out_data, {16{8'hed}});

    for (int b = 0; b < 256; b++) begin
      in_data = {16{8'(b)}};
      step();
      check1($sformatf("sweep_valid_%02h", b), out_valid, 1'b1);
      for (int l = 0; l < 16; l++) begin
        check128($sformatf("sweep_%02h_lane%0d", b, l),
                 {120'h0, out_data[8*l +: 8]}, {120'h0, ref_sbox[b]});
      end
    end

    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
    step();
    check1  ("midrst_valid", out_valid, 1'b0);
    check128("midrst_data",  out_data,  128'h0);

    rst      = 1'b0;
    in_data  = 128'ha4686b029c9f5b6a7f35ea50f22b4349;
    step();
    check1  ("postrst_valid", out_valid, 1'b1);
    check128("postrst_data",  out_data,  128'h49457f77dedb3902d296875389f11a3b);

    in_valid = 1'b0;
    step();
    check1("postrst_idle_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
